// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-way round-robin arbiter for the shared MESI line store.
//
// Grants one requester at a time. Requests are searched in round-robin order
// starting just after the most recent owner. An optional hold limit preempts
// an owner that has held the grant for MAX_HOLD cycles while another agent
// waits. The granted agent's write enable and write line are muxed onto the
// single memory write port.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req        in   [N_REQ]         per-agent level request, held until done
//   we_in      in   [N_REQ]         per-agent write enable (used only from owner)
//   wline_in   in   [N_REQ*LINE_W]  per-agent write line, agent i at [i*LINE_W +: LINE_W]
//   gnt        out  [N_REQ]         registered one-hot grant
//   owner_idx  out  [clog2(N_REQ)]  registered index of current owner
//   busy       out  |gnt
//   preempt    out  registered 1-cycle pulse: owner removed by hold limit
//   mem_we     out  memory write enable
//   mem_wline  out  [LINE_W]        memory write line ([65:64] MESI, [63:0] data)
module mem_arbiter_rr #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned LINE_W   = 66,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we_in,
  input  logic [N_REQ*LINE_W-1:0]     wline_in,
  output logic [N_REQ-1:0]            gnt,
  output logic [$clog2(N_REQ)-1:0]    owner_idx,
  output logic                        busy,
  output logic                        preempt,
  output logic                        mem_we,
  output logic [LINE_W-1:0]           mem_wline
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  // Keep the counter at least one bit wide so MAX_HOLD == 0 still elaborates.
  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand_idx;
  logic              do_grant;

  // Unpack the flat write-line bus so the owner can be selected by index.
  logic [LINE_W-1:0] lines [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : gen_lines
    assign lines[g] = wline_in[g*LINE_W +: LINE_W];
  end

  // Round-robin search from rr_ptr+1, wrapping. While busy the current owner
  // is excluded, so a found winner is always a different agent.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_idx = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && req[cand_idx] &&
          !(state_q == StBusy && cand_idx == owner_q)) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    do_grant  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) do_grant = 1'b1;
      end
      StBusy: begin
        if (!req[owner_q]) begin
          // Owner released: hand over in the same edge, or go idle.
          if (win_found) begin
            do_grant = 1'b1;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (MAX_HOLD != 0 && hold_q == HoldMax && win_found) begin
          do_grant  = 1'b1;
          preempt_d = 1'b1;
        end else if (MAX_HOLD != 0 && hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    if (do_grant) begin
      state_d           = StBusy;
      gnt_d             = '0;
      gnt_d[win_idx]    = 1'b1;
      owner_d           = win_idx;
      rr_ptr_d          = win_idx;
      hold_d            = HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= IdxW'(N_REQ - 1);
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner_idx = owner_q;
  assign busy      = |gnt_q;
  assign preempt   = preempt_q;

  // Write port follows the registered owner; gated by busy so it reads 0 when idle.
  assign mem_we    = busy & we_in[owner_q];
  assign mem_wline = busy ? lines[owner_q] : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr (N_REQ=4, MAX_HOLD=4). Expected grant and
// preempt values are queued as each step is driven and checked after the edge.
module tb_mem_arbiter_rr;

  localparam int unsigned NReq    = 4;
  localparam int unsigned LineW   = 66;
  localparam int unsigned MaxHold = 4;

  logic                    clk;
  logic                    reset;
  logic [NReq-1:0]         req;
  logic [NReq-1:0]         we_in;
  logic [NReq*LineW-1:0]   wline_in;
  logic [NReq-1:0]         gnt;
  logic [1:0]              owner_idx;
  logic                    busy;
  logic                    preempt;
  logic                    mem_we;
  logic [LineW-1:0]        mem_wline;

  logic [LineW-1:0]        lines [NReq];

  typedef struct packed {
    logic [3:0] gnt;
    logic       pre;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_rr #(
    .N_REQ    (NReq),
    .LINE_W   (LineW),
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we_in     (we_in),
    .wline_in  (wline_in),
    .gnt       (gnt),
    .owner_idx (owner_idx),
    .busy      (busy),
    .preempt   (preempt),
    .mem_we    (mem_we),
    .mem_wline (mem_wline)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LineW-1:0] got,
                     input logic [LineW-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic pack_lines();
    wline_in = {lines[3], lines[2], lines[1], lines[0]};
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Write path model: owner's we/line when busy, zero otherwise.
  task automatic chk_wpath(input string tag, input logic [3:0] eg);
    logic [1:0] i;
    if (eg != 4'b0000) begin
      i = idx_of(eg);
      chk({tag, " owner_idx"}, LineW'(owner_idx), LineW'(i));
      chk({tag, " mem_we"}, LineW'(mem_we), LineW'(we_in[i]));
      chk({tag, " mem_wline"}, mem_wline, lines[i]);
    end else begin
      chk({tag, " mem_we"}, LineW'(mem_we), '0);
      chk({tag, " mem_wline"}, mem_wline, '0);
    end
  endtask

  // Drive req, queue the expected result, clock once, pop and compare.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg,
                     input logic ep);
    exp_t e;
    req = r;
    sb.push_back('{gnt: eg, pre: ep});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " gnt"}, LineW'(gnt), LineW'(e.gnt));
    chk({tag, " busy"}, LineW'(busy), LineW'(|e.gnt));
    chk({tag, " preempt"}, LineW'(preempt), LineW'(e.pre));
    chk_wpath(tag, e.gnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " gnt"}, LineW'(gnt), '0);
    chk({tag, " busy"}, LineW'(busy), '0);
    chk({tag, " preempt"}, LineW'(preempt), '0);
    chk({tag, " owner_idx"}, LineW'(owner_idx), '0);
    chk({tag, " mem_we"}, LineW'(mem_we), '0);
    chk({tag, " mem_wline"}, mem_wline, '0);
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    we_in = 4'b1111;
    lines[0] = 66'h1_0123456789ABCDEF;
    lines[1] = 66'h3_DEADBEEF_00000000;
    lines[2] = 66'h2_5555AAAA5555AAAA;
    lines[3] = 66'h0_FEDCBA9876543210;
    pack_lines();

    #2;
    chk_reset_state("reset");
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Full contention: preempt every MaxHold cycles in order 0,1,2,3,0.
    we_in = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      cyc("rr_hold", 4'b1111, 4'b0001 << ((i / 4) % 4), (i != 0) && (i % 4 == 0));
    end

    // Releases hand over on the same edge with no idle gap.
    cyc("rel_to2", 4'b0100, 4'b0100, 1'b0);
    cyc("rel_2",   4'b1011, 4'b1000, 1'b0);
    cyc("rel_3",   4'b0011, 4'b0001, 1'b0);

    // Write path follows the owner; non-owner we/line ignored.
    we_in = 4'b0011;
    cyc("wr_own0", 4'b0011, 4'b0001, 1'b0);
    chk("wr_own0 line const", mem_wline, 66'h1_0123456789ABCDEF);
    we_in = 4'b0010;
    lines[1] = 66'h0_1111111111111111;
    pack_lines();
    #1;
    chk("wr_nonowner we", LineW'(mem_we), '0);
    chk("wr_nonowner line", mem_wline, 66'h1_0123456789ABCDEF);

    // Idle, then round-robin resumes after rr_ptr=0: order 1,2,3,0.
    we_in = 4'b1010;
    cyc("to_idle", 4'b0000, 4'b0000, 1'b0);
    cyc("rr1",     4'b1111, 4'b0010, 1'b0);
    cyc("rr2",     4'b1101, 4'b0100, 1'b0);
    cyc("rr3",     4'b1001, 4'b1000, 1'b0);
    cyc("rr0",     4'b0001, 4'b0001, 1'b0);
    cyc("idle2",   4'b0000, 4'b0000, 1'b0);

    // Lone requester is never preempted; counter saturates so a newcomer
    // preempts on the very next edge.
    for (int i = 0; i < 13; i++) cyc("lone", 4'b0100, 4'b0100, 1'b0);
    cyc("sat_pre",   4'b0101, 4'b0001, 1'b1);
    cyc("pre_pulse", 4'b0101, 4'b0001, 1'b0);
    cyc("idle3",     4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset mid-grant drops everything before the next edge.
    we_in = 4'b1111;
    cyc("pre_rst", 4'b0010, 4'b0010, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_reset_state("async_rst");
    req = 4'b0000;
    #2 reset = 1'b1;
    cyc("post_rst", 4'b0001, 4'b0001, 1'b0);
    cyc("end",      4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
